// File: rtl/riscv_mem.sv
// riscv_mem: memory-access stage of the RISC-V pipeline.
// Accepts one instruction at a time from EX over rdy/ack, performs an optional
// data-bus load/store (byte-lane steering, load sign/zero extension) and
// presents one registered result per instruction to WB over rdy/ack.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   ex_mem_rdy / ex_mem_ack        EX handshake (ex_mem_ack is combinational)
//   ex_mem_alu_op                  EX NOP flag, forwarded to mem_wb_alu_op
//   ex_mem_data                    ALU result / effective address
//   ex_mem_st_data                 store source data
//   ex_mem_ld_funct/ex_mem_st_funct load / store function codes
//   dmem_req/we/addr/be/wdata      data bus request (held until dmem_ack)
//   dmem_ack, dmem_rdata           data bus completion and read data
//   mem_wb_rdy / mem_wb_ack        WB handshake
//   mem_wb_alu_op, mem_wb_data     result payload
//   mem_wb_misalign                access was misaligned and suppressed

`ifndef RISCV_FUNCTIONS_VH
`define RISCV_FUNCTIONS_VH
`define LD_FUNCT_W 3
`define ST_FUNCT_W 2
`define LD_NOP 3'd0
`define LD_LB  3'd1
`define LD_LH  3'd2
`define LD_LW  3'd3
`define LD_LBU 3'd4
`define LD_LHU 3'd5
`define ST_NOP 2'd0
`define ST_SB  2'd1
`define ST_SH  2'd2
`define ST_SW  2'd3
`endif

module riscv_mem (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ex_mem_rdy,
  output logic                   ex_mem_ack,
  input  logic                   ex_mem_alu_op,
  input  logic [31:0]            ex_mem_data,
  input  logic [31:0]            ex_mem_st_data,
  input  logic [`LD_FUNCT_W-1:0] ex_mem_ld_funct,
  input  logic [`ST_FUNCT_W-1:0] ex_mem_st_funct,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [31:0]            dmem_rdata,
  output logic                   mem_wb_rdy,
  input  logic                   mem_wb_ack,
  output logic                   mem_wb_alu_op,
  output logic [31:0]            mem_wb_data,
  output logic                   mem_wb_misalign
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t                 r_state,      w_state_nxt;
  logic                   r_dmem_req,   w_dmem_req_nxt;
  logic                   r_dmem_we,    w_dmem_we_nxt;
  logic [31:0]            r_dmem_addr,  w_dmem_addr_nxt;
  logic [3:0]             r_dmem_be,    w_dmem_be_nxt;
  logic [31:0]            r_dmem_wdata, w_dmem_wdata_nxt;
  logic [`LD_FUNCT_W-1:0] r_ld_funct,   w_ld_funct_nxt;
  logic [1:0]             r_lane,       w_lane_nxt;
  logic                   r_acc_alu_op, w_acc_alu_op_nxt;
  logic                   r_wb_rdy,     w_wb_rdy_nxt;
  logic                   r_wb_alu_op,  w_wb_alu_op_nxt;
  logic [31:0]            r_wb_data,    w_wb_data_nxt;
  logic                   r_wb_mis,     w_wb_mis_nxt;

  logic                   w_ex_mem_ack;
  logic                   w_st_valid, w_ld_valid, w_is_st, w_is_ld, w_misalign;
  logic [3:0]             w_st_be;
  logic [31:0]            w_st_wdata;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [31:0]            w_ld_result;

  // Accept only when idle and the result slot is free or draining this cycle.
  assign w_ex_mem_ack = (r_state == S_IDLE) && (!r_wb_rdy || mem_wb_ack);

  // Decode incoming function codes; a valid store takes precedence over a load.
  always_comb begin
    w_st_valid = (ex_mem_st_funct == `ST_SB) || (ex_mem_st_funct == `ST_SH) ||
                 (ex_mem_st_funct == `ST_SW);
    w_ld_valid = (ex_mem_ld_funct == `LD_LB)  || (ex_mem_ld_funct == `LD_LH)  ||
                 (ex_mem_ld_funct == `LD_LW)  || (ex_mem_ld_funct == `LD_LBU) ||
                 (ex_mem_ld_funct == `LD_LHU);
    w_is_st    = w_st_valid;
    w_is_ld    = w_ld_valid && !w_st_valid;
    w_misalign = 1'b0;
    w_st_be    = 4'h0;
    w_st_wdata = 32'h0;
    if (w_is_st) begin
      case (ex_mem_st_funct)
        `ST_SB: begin
          w_st_be    = 4'b0001 << ex_mem_data[1:0];
          w_st_wdata = {4{ex_mem_st_data[7:0]}};
        end
        `ST_SH: begin
          w_misalign = ex_mem_data[0];
          w_st_be    = ex_mem_data[1] ? 4'b1100 : 4'b0011;
          w_st_wdata = {2{ex_mem_st_data[15:0]}};
        end
        `ST_SW: begin
          w_misalign = (ex_mem_data[1:0] != 2'b00);
          w_st_be    = 4'hF;
          w_st_wdata = ex_mem_st_data;
        end
        default: ;
      endcase
    end else if (w_is_ld) begin
      case (ex_mem_ld_funct)
        `LD_LH, `LD_LHU: w_misalign = ex_mem_data[0];
        `LD_LW:          w_misalign = (ex_mem_data[1:0] != 2'b00);
        default:         ;
      endcase
    end
  end

  // Select the addressed lane of the read word and extend per load type.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_ld_funct)
      `LD_LB:  w_ld_result = {{24{w_byte[7]}}, w_byte};
      `LD_LH:  w_ld_result = {{16{w_half[15]}}, w_half};
      `LD_LW:  w_ld_result = dmem_rdata;
      `LD_LBU: w_ld_result = {24'h0, w_byte};
      `LD_LHU: w_ld_result = {16'h0, w_half};
      default: w_ld_result = 32'h0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_dmem_req_nxt   = r_dmem_req;
    w_dmem_we_nxt    = r_dmem_we;
    w_dmem_addr_nxt  = r_dmem_addr;
    w_dmem_be_nxt    = r_dmem_be;
    w_dmem_wdata_nxt = r_dmem_wdata;
    w_ld_funct_nxt   = r_ld_funct;
    w_lane_nxt       = r_lane;
    w_acc_alu_op_nxt = r_acc_alu_op;
    w_wb_rdy_nxt     = r_wb_rdy;
    w_wb_alu_op_nxt  = r_wb_alu_op;
    w_wb_data_nxt    = r_wb_data;
    w_wb_mis_nxt     = r_wb_mis;

    if (r_wb_rdy && mem_wb_ack) begin
      w_wb_rdy_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (ex_mem_rdy && w_ex_mem_ack) begin
          if ((w_is_st || w_is_ld) && !w_misalign) begin
            w_state_nxt      = S_ACCESS;
            w_dmem_req_nxt   = 1'b1;
            w_dmem_we_nxt    = w_is_st;
            w_dmem_addr_nxt  = {ex_mem_data[31:2], 2'b00};
            w_dmem_be_nxt    = w_is_st ? w_st_be : 4'hF;
            w_dmem_wdata_nxt = w_is_st ? w_st_wdata : 32'h0;
            w_ld_funct_nxt   = w_is_st ? `LD_NOP : ex_mem_ld_funct;
            w_lane_nxt       = ex_mem_data[1:0];
            w_acc_alu_op_nxt = ex_mem_alu_op;
          end else begin
            // NOP or suppressed misaligned access: result next cycle.
            w_wb_rdy_nxt    = 1'b1;
            w_wb_alu_op_nxt = ex_mem_alu_op;
            w_wb_data_nxt   = (w_is_st || w_is_ld) ? 32'h0 : ex_mem_data;
            w_wb_mis_nxt    = w_misalign;
          end
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          w_state_nxt     = S_IDLE;
          w_dmem_req_nxt  = 1'b0;
          w_wb_rdy_nxt    = 1'b1;
          w_wb_alu_op_nxt = r_acc_alu_op;
          w_wb_data_nxt   = r_dmem_we ? 32'h0 : w_ld_result;
          w_wb_mis_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_be    <= 4'h0;
      r_dmem_wdata <= 32'h0;
      r_ld_funct   <= `LD_NOP;
      r_lane       <= 2'd0;
      r_acc_alu_op <= 1'b0;
      r_wb_rdy     <= 1'b0;
      r_wb_alu_op  <= 1'b0;
      r_wb_data    <= 32'h0;
      r_wb_mis     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dmem_req   <= w_dmem_req_nxt;
      r_dmem_we    <= w_dmem_we_nxt;
      r_dmem_addr  <= w_dmem_addr_nxt;
      r_dmem_be    <= w_dmem_be_nxt;
      r_dmem_wdata <= w_dmem_wdata_nxt;
      r_ld_funct   <= w_ld_funct_nxt;
      r_lane       <= w_lane_nxt;
      r_acc_alu_op <= w_acc_alu_op_nxt;
      r_wb_rdy     <= w_wb_rdy_nxt;
      r_wb_alu_op  <= w_wb_alu_op_nxt;
      r_wb_data    <= w_wb_data_nxt;
      r_wb_mis     <= w_wb_mis_nxt;
    end
  end

  assign ex_mem_ack      = w_ex_mem_ack;
  assign dmem_req        = r_dmem_req;
  assign dmem_we         = r_dmem_we;
  assign dmem_addr       = r_dmem_addr;
  assign dmem_be         = r_dmem_be;
  assign dmem_wdata      = r_dmem_wdata;
  assign mem_wb_rdy      = r_wb_rdy;
  assign mem_wb_alu_op   = r_wb_alu_op;
  assign mem_wb_data     = r_wb_data;
  assign mem_wb_misalign = r_wb_mis;

endmodule

// File: tb/tb_riscv_mem.sv
// Scoreboard bench for riscv_mem: directed instructions push expected WB
// results and expected bus requests; a WB monitor and a bus responder pop
// and compare whenever the DUT presents a transfer.
`timescale 1ns/1ps

module tb_riscv_mem;

  localparam logic [2:0] LNOP = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3,
                         LBU = 3'd4, LHU = 3'd5;
  localparam logic [1:0] SNOP = 2'd0, SB = 2'd1, SH = 2'd2, SW = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_mem_rdy, ex_mem_ack, ex_mem_alu_op;
  logic [31:0] ex_mem_data, ex_mem_st_data;
  logic [2:0]  ex_mem_ld_funct;
  logic [1:0]  ex_mem_st_funct;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_wb_rdy, mem_wb_ack, mem_wb_alu_op, mem_wb_misalign;
  logic [31:0] mem_wb_data;

  riscv_mem dut (
    .clk(clk), .rstn(rstn),
    .ex_mem_rdy(ex_mem_rdy), .ex_mem_ack(ex_mem_ack), .ex_mem_alu_op(ex_mem_alu_op),
    .ex_mem_data(ex_mem_data), .ex_mem_st_data(ex_mem_st_data),
    .ex_mem_ld_funct(ex_mem_ld_funct), .ex_mem_st_funct(ex_mem_st_funct),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(mem_wb_ack), .mem_wb_alu_op(mem_wb_alu_op),
    .mem_wb_data(mem_wb_data), .mem_wb_misalign(mem_wb_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic aop; logic [31:0] data; logic mis; } wb_exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; logic chk_wdata; } bus_exp_t;

  wb_exp_t  sb_q[$];
  bus_exp_t bus_q[$];
  int       pop_cyc[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int          bus_wait  = 0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stray_ack = 1'b0;
  int          last_req_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // WB monitor: one result per rdy&&ack transfer.
  always @(negedge clk) begin
    if (rstn && mem_wb_rdy && mem_wb_ack) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected_result", mem_wb_data, 32'hDEAD_BEEF);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        pop_cyc.push_back(cyc);
        chk("wb_data",     mem_wb_data, e.data);
        chk("wb_misalign", 32'(mem_wb_misalign), 32'(e.mis));
        chk("wb_alu_op",   32'(mem_wb_alu_op), 32'(e.aop));
      end
    end
  end

  // Bus responder: checks request fields every req cycle, acks after bus_wait.
  int       rcnt = 0;
  bus_exp_t cur;
  logic     cur_valid = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      rcnt     = 0;
      dmem_ack = 1'b0;
    end else if (dmem_req) begin
      if (rcnt == 0) begin
        if (bus_q.size() == 0) begin
          cur_valid = 1'b0;
          chk("bus_unexpected_req", dmem_addr, 32'hFFFF_FFFF);
        end else begin
          cur       = bus_q.pop_front();
          cur_valid = 1'b1;
        end
      end
      if (cur_valid) begin
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_we",   32'(dmem_we), 32'(cur.we));
        chk("dmem_be",   32'(dmem_be), 32'(cur.be));
        if (cur.chk_wdata) chk("dmem_wdata", dmem_wdata, cur.wdata);
      end
      chk("ex_ack_during_access", 32'(ex_mem_ack), 32'd0);
      if (rcnt == bus_wait) begin
        dmem_ack     = 1'b1;
        dmem_rdata   = bus_rdata;
        last_req_len = rcnt + 1;
        rcnt         = 0;
      end else begin
        dmem_ack = 1'b0;
        rcnt++;
      end
    end else begin
      rcnt     = 0;
      dmem_ack = stray_ack;
    end
  end

  task automatic push_wb(input logic aop, input logic [31:0] d, input logic mis);
    wb_exp_t e;
    e.aop = aop; e.data = d; e.mis = mis;
    sb_q.push_back(e);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic cw);
    bus_exp_t e;
    e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.chk_wdata = cw;
    bus_q.push_back(e);
  endtask

  // Present one instruction until accepted; called at posedge+1.
  task automatic issue(input logic aop, input logic [31:0] d, input logic [31:0] st,
                       input logic [2:0] ld, input logic [1:0] sf, output int waits);
    ex_mem_rdy = 1'b1; ex_mem_alu_op = aop; ex_mem_data = d;
    ex_mem_st_data = st; ex_mem_ld_funct = ld; ex_mem_st_funct = sf;
    waits = 0;
    forever begin
      @(negedge clk);
      if (ex_mem_ack) break;
      waits++;
      if (waits > 100) begin
        chk("issue_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    ex_mem_rdy = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0 && bus_q.size() == 0 && !dmem_req && !mem_wb_rdy) break;
      n++;
      if (n > 200) begin
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rstn = 1'b0; ex_mem_rdy = 1'b0; ex_mem_alu_op = 1'b0; ex_mem_data = 32'h0;
    ex_mem_st_data = 32'h0; ex_mem_ld_funct = LNOP; ex_mem_st_funct = SNOP;
    dmem_ack = 1'b0; dmem_rdata = 32'h0; mem_wb_ack = 1'b1;

    #2;
    chk("rst_dmem_req",   32'(dmem_req), 32'd0);
    chk("rst_mem_wb_rdy", 32'(mem_wb_rdy), 32'd0);
    chk("rst_mem_wb_data", mem_wb_data, 32'h0);
    chk("rst_dmem_be",    32'(dmem_be), 32'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // NOP passthrough, back-to-back.
    pop_cyc.delete();
    push_wb(1'b0, 32'h11, 1'b0); push_wb(1'b1, 32'h22, 1'b0); push_wb(1'b0, 32'h33, 1'b0);
    issue(1'b0, 32'h11, 32'h0, LNOP, SNOP, w); chk("nop0_wait", 32'(w), 32'd0);
    issue(1'b1, 32'h22, 32'h0, LNOP, SNOP, w); chk("nop1_wait", 32'(w), 32'd0);
    issue(1'b0, 32'h33, 32'h0, LNOP, SNOP, w); chk("nop2_wait", 32'(w), 32'd0);
    drain();
    if (pop_cyc.size() == 3) begin
      chk("nop_consec_a", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      chk("nop_consec_b", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end else chk("nop_pop_count", 32'(pop_cyc.size()), 32'd3);

    // LB with two wait cycles.
    bus_wait = 2; bus_rdata = 32'h80FF_1234;
    push_bus(32'h1000, 1'b0, 4'hF, 32'h0, 1'b0); push_wb(1'b1, 32'hFFFF_FF80, 1'b0);
    issue(1'b1, 32'h1003, 32'h0, LB, SNOP, w); drain();
    chk("lb_req_len", 32'(last_req_len), 32'd3);
    // LBU same lane.
    bus_wait = 0;
    push_bus(32'h1000, 1'b0, 4'hF, 32'h0, 1'b0); push_wb(1'b0, 32'h0000_0080, 1'b0);
    issue(1'b0, 32'h1003, 32'h0, LBU, SNOP, w); drain();
    chk("lbu_req_len", 32'(last_req_len), 32'd1);

    // LHU / LH upper half.
    bus_rdata = 32'hBEEF_0000;
    push_bus(32'h2000, 1'b0, 4'hF, 32'h0, 1'b0); push_wb(1'b0, 32'h0000_BEEF, 1'b0);
    issue(1'b0, 32'h2002, 32'h0, LHU, SNOP, w); drain();
    push_bus(32'h2000, 1'b0, 4'hF, 32'h0, 1'b0); push_wb(1'b0, 32'hFFFF_BEEF, 1'b0);
    issue(1'b0, 32'h2002, 32'h0, LH, SNOP, w); drain();
    // LW aligned.
    bus_rdata = 32'h1234_5678;
    push_bus(32'h4000, 1'b0, 4'hF, 32'h0, 1'b0); push_wb(1'b0, 32'h1234_5678, 1'b0);
    issue(1'b0, 32'h4000, 32'h0, LW, SNOP, w); drain();

    // Stores.
    bus_wait = 1;
    push_bus(32'h3000, 1'b1, 4'b0010, 32'hDDDD_DDDD, 1'b1); push_wb(1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h3001, 32'hAABB_CCDD, LNOP, SB, w); drain();
    push_bus(32'h3000, 1'b1, 4'b1100, 32'hCCDD_CCDD, 1'b1); push_wb(1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h3002, 32'hAABB_CCDD, LNOP, SH, w); drain();
    bus_wait = 0;
    push_bus(32'h3004, 1'b1, 4'hF, 32'hAABB_CCDD, 1'b1); push_wb(1'b1, 32'h0, 1'b0);
    issue(1'b1, 32'h3004, 32'hAABB_CCDD, LNOP, SW, w); drain();
    // Load and store both set: store wins.
    push_bus(32'h5000, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1); push_wb(1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h5000, 32'hCAFE_F00D, LB, SW, w); drain();

    // Misaligned accesses: no bus request, result next cycle.
    push_wb(1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h4002, 32'h0, LW, SNOP, w); drain();
    push_wb(1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h2001, 32'h0, LH, SNOP, w); drain();
    push_wb(1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h3002, 32'h1111_2222, LNOP, SW, w); drain();
    // Unknown load code behaves as NOP.
    push_wb(1'b1, 32'h77, 1'b0);
    issue(1'b1, 32'h77, 32'h0, 3'd7, SNOP, w); drain();

    // WB backpressure.
    mem_wb_ack = 1'b0;
    push_wb(1'b1, 32'h55, 1'b0);
    issue(1'b1, 32'h55, 32'h0, LNOP, SNOP, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rdy",     32'(mem_wb_rdy), 32'd1);
      chk("bp_data",    mem_wb_data, 32'h55);
      chk("bp_alu_op",  32'(mem_wb_alu_op), 32'd1);
      chk("bp_ex_ack",  32'(ex_mem_ack), 32'd0);
    end
    @(posedge clk); #1;
    mem_wb_ack = 1'b1;
    drain();

    // Reset during an access, then a stray ack.
    bus_wait = 20;
    push_bus(32'h6000, 1'b0, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 32'h6000, 32'h0, LW, SNOP, w);
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_rdy", 32'(mem_wb_rdy), 32'd0);
    @(negedge clk); #1;
    rstn = 1'b1;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_rdy", 32'(mem_wb_rdy), 32'd0);
      chk("stray_req", 32'(dmem_req), 32'd0);
    end
    stray_ack = 1'b0;
    @(posedge clk); #1;
    bus_wait = 0;
    push_wb(1'b0, 32'h99, 1'b0);
    issue(1'b0, 32'h99, 32'h0, LNOP, SNOP, w); drain();

    chk("sb_q_empty",  32'(sb_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem.md
Name: riscv_mem

Overview:
- Memory-access stage of the RISC-V pipeline, sitting downstream of the execute stage.
- Receiver end of the EX-to-MEM rdy/ack interface. Consumes ALU result/address, store data and load/store function codes.
- Performs data-memory loads/stores over a req/ack data bus, with byte-lane steering and load sign/zero extension.
- Presents one registered result per accepted instruction to writeback over the same rdy/ack style.

Parameters:
- none. Function widths/encodings come from riscv_functions.vh: `LD_FUNCT_W`, `ST_FUNCT_W`, `LD_NOP/LB/LH/LW/LBU/LHU`, `ST_NOP/SB/SH/SW`.

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
ex_mem_rdy  in  1  EX holds valid instruction
ex_mem_ack  out  1  MEM accepts (transfer = rdy&&ack at posedge)
ex_mem_alu_op  in  1  EX-NOP flag, forwarded unchanged
ex_mem_data  in  32  ALU result / effective address
ex_mem_st_data  in  32  store source data
ex_mem_ld_funct  in  LD_FUNCT_W  load function
ex_mem_st_funct  in  ST_FUNCT_W  store function
dmem_req  out  1  data bus request
dmem_we  out  1  1=write
dmem_addr  out  32  word address, [1:0]=0
dmem_be  out  4  byte enables
dmem_wdata  out  32  write data
dmem_ack  in  1  bus completes request this cycle
dmem_rdata  in  32  read data, valid with dmem_ack
mem_wb_rdy  out  1  result valid
mem_wb_ack  in  1  WB accepts
mem_wb_alu_op  out  1  forwarded ex_mem_alu_op
mem_wb_data  out  32  writeback value
mem_wb_misalign  out  1  access was misaligned, suppressed

Behaviour:
- Reset (`rstn` is asynchronous, active-low; clock is `clk`): all outputs 0, state IDLE. Takes effect immediately, even mid-access.
  - `dmem_req` drops at once; the outstanding access is abandoned.
  - A later `dmem_ack` for the abandoned access is ignored.
- States:
  - IDLE: may accept.
  - ACCESS: `dmem_req` asserted, waiting for `dmem_ack`.
- `ex_mem_ack` (combinational) = (state==IDLE) && (!mem_wb_rdy || mem_wb_ack).
- Accept cycle T, no memory op (both functs NOP):
  - At T+1: mem_wb_rdy=1, mem_wb_data=ex_mem_data, misalign=0, state stays IDLE.
  - Latency 1; back-to-back throughput 1/cycle.
- Accept cycle T, load or store:
  - Address a=ex_mem_data.
  - Misaligned = halfword with a[0]=1, or word with a[1:0]!=0.
  - Misaligned: no bus access; at T+1 mem_wb_rdy=1, data=0, misalign=1.
  - Aligned: at T+1 state=ACCESS, dmem_req=1, dmem_addr={a[31:2],2'b00}.
  - dmem_we, dmem_be, dmem_wdata and the captured ld funct/lane stay stable until `dmem_ack` is sampled high.
  - mem_wb_rdy is 0 throughout ACCESS.
- Completion:
  - At the posedge where dmem_req && dmem_ack: state→IDLE, dmem_req→0, mem_wb_rdy→1 with the result.
  - Minimum latency 2 cycles (ack in the first req cycle).
  - dmem_ack while dmem_req=0 is ignored.
- Store encoding:
  - SB: be=4'b0001<<a[1:0], wdata={4{st_data[7:0]}}.
  - SH: be=a[1]?1100:0011, wdata={2{st_data[15:0]}}.
  - SW: be=1111, wdata=st_data.
  - Store result: mem_wb_data=0.
- Load encoding:
  - dmem_we=0, be=1111.
  - Lane byte = rdata[8*a[1:0]+:8]; lane half = rdata[16*a[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW = rdata.
- Both ld and st non-NOP: treated as store, load ignored.
- Unknown funct codes: treated as NOP.
- Output hold: mem_wb_* hold stable while mem_wb_rdy && !mem_wb_ack. mem_wb_rdy clears after ack if nothing new is loaded.
- mem_wb_alu_op always equals the accepted instruction's ex_mem_alu_op.

Test Plan:
- NOP passthrough: 3 back-to-back rdy with data 0x11,0x22,0x33, mem_wb_ack=1 → mem_wb_data 0x11,0x22,0x33 on consecutive cycles, ex_mem_ack constantly 1.
- LB at a=0x1003, dmem_ack after 2 wait cycles, rdata=0x80FF_1234 → dmem_addr=0x1000, req held 3 cycles, ex_mem_ack=0 meanwhile, mem_wb_data=0xFFFF_FF80.
- LHU a=0x2002, rdata=0xBEEF_0000 → 0x0000_BEEF; LH same → 0xFFFF_BEEF.
- SB a=0x3001, st_data=0xAABB_CCDD → dmem_we=1, be=0010, wdata=0xDDDD_DDDD, mem_wb_data=0; SH a=0x3002 → be=1100, wdata=0xCCDD_CCDD.
- LW a=0x4002 → no dmem_req, next cycle mem_wb_rdy=1, misalign=1, data=0.
- WB backpressure: mem_wb_ack=0 for 4 cycles with result pending → outputs stable, ex_mem_ack=0. Assert rstn=0 during an ACCESS wait → dmem_req=0 and mem_wb_rdy=0 immediately; after release, a stray dmem_ack produces no output.
